// File: rtl/lift_call_scheduler.sv
// lift_call_scheduler
//   Upstream stage of the lift controller. It synchronises the raw floor-call
//   buttons for floors A..D and latches each call into a pending set. It issues
//   one one-hot request at a time under a directional nearest-call policy. It
//   also times the door-open dwell at each served floor and then retires the call.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   btn_a..btn_d   raw asynchronous call buttons (level)
//   floor[2:0]     lift state code: 0=A 1=B-up 2=B-down 3=C-up 4=C-down 5=D, 6/7 invalid
//   ra..rd         registered one-hot request to the lift
//   pending[3:0]   registered latched calls, bit0=A .. bit3=D
//   door_open      registered door-open indicator
module lift_call_scheduler #(
  parameter int DOOR_CYCLES = 8,
  parameter int DOOR_W      = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_a,
  input  logic       btn_b,
  input  logic       btn_c,
  input  logic       btn_d,
  input  logic [2:0] floor,
  output logic       ra,
  output logic       rb,
  output logic       rc,
  output logic       rd,
  output logic [3:0] pending,
  output logic       door_open
);

  typedef enum logic [1:0] {IDLE, SERVE, DOOR} state_t;

  localparam logic [DOOR_W-1:0] LP_CNT_LOAD = DOOR_W'(DOOR_CYCLES - 1);

  state_t              r_state;
  logic [3:0]          r_s1, r_s2, r_s3;
  logic [3:0]          r_pending;
  logic [3:0]          r_req;
  logic                r_door;
  logic                r_dir_up;
  logic [1:0]          r_target;
  logic [DOOR_W-1:0]   r_cnt;

  logic [3:0]          w_rise;
  logic [3:0]          w_clr;
  logic                w_cur_vld;
  logic [1:0]          w_cur;
  logic [1:0]          w_sel;

  function automatic logic [3:0] onehot(input logic [1:0] idx);
    onehot = 4'b0001 << idx;
  endfunction

  // Directional nearest-call choice. Only used when pending[cur] is clear and
  // pending is nonzero, so at least one of the two candidates exists.
  function automatic logic [1:0] pick(input logic [3:0] p, input logic [1:0] cur,
                                      input logic up);
    logic [1:0] above, below;
    logic       has_above, has_below;
    above     = 2'd0;
    below     = 2'd0;
    has_above = 1'b0;
    has_below = 1'b0;
    // Descending scan leaves the smallest index above cur.
    for (int k = 3; k >= 0; k--) begin
      if (p[k] && (2'(k) > cur)) begin
        above     = 2'(k);
        has_above = 1'b1;
      end
    end
    // Ascending scan leaves the largest index below cur.
    for (int k = 0; k < 4; k++) begin
      if (p[k] && (2'(k) < cur)) begin
        below     = 2'(k);
        has_below = 1'b1;
      end
    end
    if (up) pick = has_above ? above : below;
    else    pick = has_below ? below : above;
  endfunction

  always_comb begin
    w_cur_vld = 1'b1;
    w_cur     = 2'd0;
    case (floor)
      3'd0:       w_cur = 2'd0;
      3'd1, 3'd2: w_cur = 2'd1;
      3'd3, 3'd4: w_cur = 2'd2;
      3'd5:       w_cur = 2'd3;
      default:    w_cur_vld = 1'b0;
    endcase
  end

  assign w_rise = r_s2 & ~r_s3;
  assign w_sel  = pick(r_pending, w_cur, r_dir_up);
  // Retire the served call on the edge that ends the dwell; this also swallows
  // a coincident new call for the same floor.
  assign w_clr  = ((r_state == DOOR) && (r_cnt == '0)) ? onehot(r_target) : 4'b0000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1      <= '0;
      r_s2      <= '0;
      r_s3      <= '0;
      r_pending <= '0;
    end else begin
      r_s1      <= {btn_d, btn_c, btn_b, btn_a};
      r_s2      <= r_s1;
      r_s3      <= r_s2;
      r_pending <= (r_pending | w_rise) & ~w_clr;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_req    <= '0;
      r_door   <= 1'b0;
      r_dir_up <= 1'b1;
      r_target <= 2'd0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_cur_vld && (r_pending != 4'b0000)) begin
            if (r_pending[w_cur]) begin
              r_state  <= DOOR;
              r_target <= w_cur;
              r_req    <= onehot(w_cur);
              r_cnt    <= LP_CNT_LOAD;
              r_door   <= 1'b1;
            end else begin
              r_state  <= SERVE;
              r_target <= w_sel;
              r_req    <= onehot(w_sel);
              r_dir_up <= (w_sel > w_cur);
            end
          end
        end
        SERVE: begin
          if (w_cur_vld && (w_cur == r_target)) begin
            r_state <= DOOR;
            r_cnt   <= LP_CNT_LOAD;
            r_door  <= 1'b1;
          end
        end
        DOOR: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_door  <= 1'b0;
            r_req   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign {rd, rc, rb, ra} = r_req;
  assign pending          = r_pending;
  assign door_open        = r_door;

endmodule
